// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - instruction queue between branch select/check and decode
module inst_fetch_queue #(
   parameter int DEPTH = 16,
   parameter int CP_W  = 24
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush_i,
   input  logic                IF_valid_i,
   input  logic [2:0]          IF_instNum_i,
   input  logic [127:0]        IF_inst_p_i,
   input  logic [127:0]        IF_predDest_p_i,
   input  logic [3:0]          IF_predTake_p_i,
   input  logic [4*CP_W-1:0]   IF_predInfo_p_i,
   input  logic [31:0]         IF_instBasePC_i,
   input  logic                IF_hasException_i,
   input  logic [4:0]          IF_ExcCode_i,
   input  logic                IF_isRefill_i,
   output logic                IQ_full_o,
   input  logic [1:0]          ID_readNum_i,
   output logic [1:0]          IQ_valid_o,
   output logic [63:0]         IQ_inst_p_o,
   output logic [63:0]         IQ_PC_p_o,
   output logic [63:0]         IQ_predDest_p_o,
   output logic [1:0]          IQ_predTake_p_o,
   output logic [2*CP_W-1:0]   IQ_predInfo_p_o,
   output logic [13:0]         IQ_exc_p_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [31:0]     instMem [DEPTH];
   logic [31:0]     pcMem   [DEPTH];
   logic [31:0]     destMem [DEPTH];
   logic            takeMem [DEPTH];
   logic [CP_W-1:0] infoMem [DEPTH];
   logic [6:0]      excMem  [DEPTH];

   logic [AW-1:0] head, tail;
   logic [CW-1:0] count;
   logic          wrEn;
   logic [2:0]    wrNum;
   logic [1:0]    rdReq, rdNum;
   logic [AW-1:0] slotIdx [2];

   assign IQ_full_o = (CW'(DEPTH) - count) < CW'(4);

   always_comb begin
      wrEn  = IF_valid_i && !IQ_full_o && !flush_i;
      wrNum = 3'd0;
      if (wrEn) wrNum = (IF_instNum_i > 3'd4) ? 3'd4 : IF_instNum_i;
      rdReq = (ID_readNum_i > 2'd2) ? 2'd2 : ID_readNum_i;
      // Clamp the read to what is actually stored so head never overruns tail.
      rdNum = (count < CW'(rdReq)) ? count[1:0] : rdReq;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush_i) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + AW'(rdNum);
         tail  <= tail + AW'(wrNum);
         count <= count + CW'(wrNum) - CW'(rdNum);
      end
   end

   // Storage is not reset; outputs are masked by slot validity instead.
   always_ff @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (3'(k) < wrNum) begin
            instMem[tail + AW'(k)] <= IF_inst_p_i[32*k +: 32];
            pcMem  [tail + AW'(k)] <= IF_instBasePC_i + 32'(4 * k);
            destMem[tail + AW'(k)] <= IF_predDest_p_i[32*k +: 32];
            takeMem[tail + AW'(k)] <= IF_predTake_p_i[k];
            infoMem[tail + AW'(k)] <= IF_predInfo_p_i[CP_W*k +: CP_W];
            excMem [tail + AW'(k)] <= {IF_hasException_i, IF_isRefill_i, IF_ExcCode_i};
         end
      end
   end

   always_comb begin
      IQ_valid_o      = {count >= CW'(2), count >= CW'(1)};
      IQ_inst_p_o     = '0;
      IQ_PC_p_o       = '0;
      IQ_predDest_p_o = '0;
      IQ_predTake_p_o = '0;
      IQ_predInfo_p_o = '0;
      IQ_exc_p_o      = '0;
      slotIdx[0]      = head;
      slotIdx[1]      = head + AW'(1);
      for (int k = 0; k < 2; k++) begin
         if (IQ_valid_o[k]) begin
            IQ_inst_p_o[32*k +: 32]       = instMem[slotIdx[k]];
            IQ_PC_p_o[32*k +: 32]         = pcMem[slotIdx[k]];
            IQ_predDest_p_o[32*k +: 32]   = destMem[slotIdx[k]];
            IQ_predTake_p_o[k]            = takeMem[slotIdx[k]];
            IQ_predInfo_p_o[CP_W*k +: CP_W] = infoMem[slotIdx[k]];
            IQ_exc_p_o[7*k +: 7]          = excMem[slotIdx[k]];
         end
      end
   end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - directed vector bench for inst_fetch_queue
module tb_inst_fetch_queue;
   localparam int CP_W = 24;

   logic              clk = 1'b0;
   logic              rst;
   logic              flush_i;
   logic              IF_valid_i;
   logic [2:0]        IF_instNum_i;
   logic [127:0]      IF_inst_p_i;
   logic [127:0]      IF_predDest_p_i;
   logic [3:0]        IF_predTake_p_i;
   logic [4*CP_W-1:0] IF_predInfo_p_i;
   logic [31:0]       IF_instBasePC_i;
   logic              IF_hasException_i;
   logic [4:0]        IF_ExcCode_i;
   logic              IF_isRefill_i;
   logic              IQ_full_o;
   logic [1:0]        ID_readNum_i;
   logic [1:0]        IQ_valid_o;
   logic [63:0]       IQ_inst_p_o;
   logic [63:0]       IQ_PC_p_o;
   logic [63:0]       IQ_predDest_p_o;
   logic [1:0]        IQ_predTake_p_o;
   logic [2*CP_W-1:0] IQ_predInfo_p_o;
   logic [13:0]       IQ_exc_p_o;

   inst_fetch_queue #(.DEPTH(16), .CP_W(CP_W)) dut (
      .clk(clk), .rst(rst), .flush_i(flush_i),
      .IF_valid_i(IF_valid_i), .IF_instNum_i(IF_instNum_i),
      .IF_inst_p_i(IF_inst_p_i), .IF_predDest_p_i(IF_predDest_p_i),
      .IF_predTake_p_i(IF_predTake_p_i), .IF_predInfo_p_i(IF_predInfo_p_i),
      .IF_instBasePC_i(IF_instBasePC_i), .IF_hasException_i(IF_hasException_i),
      .IF_ExcCode_i(IF_ExcCode_i), .IF_isRefill_i(IF_isRefill_i),
      .IQ_full_o(IQ_full_o), .ID_readNum_i(ID_readNum_i),
      .IQ_valid_o(IQ_valid_o), .IQ_inst_p_o(IQ_inst_p_o), .IQ_PC_p_o(IQ_PC_p_o),
      .IQ_predDest_p_o(IQ_predDest_p_o), .IQ_predTake_p_o(IQ_predTake_p_o),
      .IQ_predInfo_p_o(IQ_predInfo_p_o), .IQ_exc_p_o(IQ_exc_p_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        flush, valid;
      logic [2:0]  num;
      logic [31:0] pcBase, instBase, instStep;
      logic [1:0]  rd;
      logic        exc, refill;
      logic [4:0]  code;
      logic [1:0]  eValid;
      logic        eFull;
      logic [31:0] eInst0, eInst1, ePc0, ePc1;
      logic [6:0]  eExc0, eExc1;
   } vec_t;

   vec_t vecs[$];
   int   nTests = 0;
   int   nFail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic fl, input logic va, input logic [2:0] n,
                               input logic [31:0] pcb, input logic [31:0] ib, input logic [31:0] st,
                               input logic [1:0] rd, input logic ex, input logic [4:0] cd,
                               input logic [1:0] ev, input logic ef,
                               input logic [31:0] ei0, input logic [31:0] ei1,
                               input logic [31:0] ep0, input logic [31:0] ep1,
                               input logic [6:0] ee0, input logic [6:0] ee1);
      vec_t v;
      v.flush = fl; v.valid = va; v.num = n; v.pcBase = pcb; v.instBase = ib; v.instStep = st;
      v.rd = rd; v.exc = ex; v.refill = 1'b0; v.code = cd;
      v.eValid = ev; v.eFull = ef; v.eInst0 = ei0; v.eInst1 = ei1;
      v.ePc0 = ep0; v.ePc1 = ep1; v.eExc0 = ee0; v.eExc1 = ee1;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      logic [31:0] w;
      flush_i = v.flush; IF_valid_i = v.valid; IF_instNum_i = v.num;
      IF_instBasePC_i = v.pcBase; ID_readNum_i = v.rd;
      IF_hasException_i = v.exc; IF_isRefill_i = v.refill; IF_ExcCode_i = v.code;
      for (int k = 0; k < 4; k++) begin
         w = v.instBase + v.instStep * k;
         IF_inst_p_i[32*k +: 32]          = w;
         IF_predDest_p_i[32*k +: 32]      = w ^ 32'hFFFF0000;
         IF_predTake_p_i[k]               = w[0];
         IF_predInfo_p_i[CP_W*k +: CP_W]  = w[CP_W-1:0] ^ 24'h5A5A5A;
      end
   endtask

   task automatic checkVec(input int i, input vec_t v);
      string s;
      s = $sformatf("v%0d", i);
      check({s, ".valid"}, 64'(IQ_valid_o), 64'(v.eValid));
      check({s, ".full"},  64'(IQ_full_o),  64'(v.eFull));
      check({s, ".inst0"}, 64'(IQ_inst_p_o[31:0]),  64'(v.eInst0));
      check({s, ".inst1"}, 64'(IQ_inst_p_o[63:32]), 64'(v.eInst1));
      check({s, ".pc0"},   64'(IQ_PC_p_o[31:0]),    64'(v.ePc0));
      check({s, ".pc1"},   64'(IQ_PC_p_o[63:32]),   64'(v.ePc1));
      check({s, ".exc0"},  64'(IQ_exc_p_o[6:0]),    64'(v.eExc0));
      check({s, ".exc1"},  64'(IQ_exc_p_o[13:7]),   64'(v.eExc1));
      check({s, ".dest1"}, 64'(IQ_predDest_p_o[63:32]),
            v.eValid[1] ? 64'(v.eInst1 ^ 32'hFFFF0000) : 64'd0);
      check({s, ".take"},  64'(IQ_predTake_p_o),
            64'({v.eValid[1] & v.eInst1[0], v.eValid[0] & v.eInst0[0]}));
      check({s, ".info0"}, 64'(IQ_predInfo_p_o[CP_W-1:0]),
            v.eValid[0] ? 64'(v.eInst0[CP_W-1:0] ^ 24'h5A5A5A) : 64'd0);
   endtask

   initial begin
      vec_t idle;
      rst = 1'b0;
      idle = mk(0,0,0, 0,0,0, 0, 0,0, 2'b00,0, 0,0,0,0, 0,0);
      drive(idle);
      repeat (2) @(posedge clk);
      #1;
      check("rst.valid", 64'(IQ_valid_o), 64'd0);
      check("rst.full",  64'(IQ_full_o),  64'd0);
      check("rst.inst",  IQ_inst_p_o,     64'd0);
      check("rst.pc",    IQ_PC_p_o,       64'd0);
      @(negedge clk);
      rst = 1'b1;

      // Fill to full, hold a 5th group, drain and refill across the wrap point
      vecs.push_back(mk(0,1,4, 32'hBFC00000,32'h100,1, 0, 0,0, 2'b11,0, 32'h100,32'h101,32'hBFC00000,32'hBFC00004, 0,0));
      vecs.push_back(mk(0,1,4, 32'hBFC00010,32'h200,1, 0, 0,0, 2'b11,0, 32'h100,32'h101,32'hBFC00000,32'hBFC00004, 0,0));
      vecs.push_back(mk(0,1,4, 32'hBFC00020,32'h300,1, 0, 0,0, 2'b11,0, 32'h100,32'h101,32'hBFC00000,32'hBFC00004, 0,0));
      vecs.push_back(mk(0,1,4, 32'hBFC00030,32'h400,1, 0, 0,0, 2'b11,1, 32'h100,32'h101,32'hBFC00000,32'hBFC00004, 0,0));
      vecs.push_back(mk(0,1,4, 32'hBFC00040,32'h500,1, 0, 0,0, 2'b11,1, 32'h100,32'h101,32'hBFC00000,32'hBFC00004, 0,0));
      vecs.push_back(mk(0,0,0, 0,0,0, 2, 0,0, 2'b11,1, 32'h102,32'h103,32'hBFC00008,32'hBFC0000C, 0,0));
      vecs.push_back(mk(0,1,4, 32'h1000,32'h600,1, 2, 0,0, 2'b11,0, 32'h200,32'h201,32'hBFC00010,32'hBFC00014, 0,0));
      vecs.push_back(mk(0,1,4, 32'h1000,32'h600,1, 2, 0,0, 2'b11,1, 32'h202,32'h203,32'hBFC00018,32'hBFC0001C, 0,0));
      vecs.push_back(mk(0,0,0, 0,0,0, 2, 0,0, 2'b11,0, 32'h300,32'h301,32'hBFC00020,32'hBFC00024, 0,0));
      vecs.push_back(mk(0,0,0, 0,0,0, 2, 0,0, 2'b11,0, 32'h302,32'h303,32'hBFC00028,32'hBFC0002C, 0,0));
      // Flush beats a simultaneous write and read
      vecs.push_back(mk(1,1,3, 32'h2000,32'h700,1, 2, 0,0, 2'b00,0, 0,0,0,0, 0,0));
      // Exception group: tags copied to both instructions
      vecs.push_back(mk(0,1,2, 32'h80000000,32'h0,0, 0, 1,5'h04, 2'b11,0, 0,0,32'h80000000,32'h80000004, 7'b1000100,7'b1000100));
      vecs.push_back(mk(0,0,0, 0,0,0, 3, 0,0, 2'b00,0, 0,0,0,0, 0,0));
      // Oversized read on a single entry clamps to one
      vecs.push_back(mk(0,1,1, 32'h100,32'h800,1, 0, 0,0, 2'b01,0, 32'h800,0,32'h100,0, 0,0));
      vecs.push_back(mk(0,0,0, 0,0,0, 2, 0,0, 2'b00,0, 0,0,0,0, 0,0));
      // Walk head to 14 with two entries left, then write while reading
      vecs.push_back(mk(0,1,4, 32'h200,32'h900,1, 0, 0,0, 2'b11,0, 32'h900,32'h901,32'h200,32'h204, 0,0));
      vecs.push_back(mk(0,1,4, 32'h300,32'hA00,1, 2, 0,0, 2'b11,0, 32'h902,32'h903,32'h208,32'h20C, 0,0));
      vecs.push_back(mk(0,1,4, 32'h400,32'hB00,1, 2, 0,0, 2'b11,0, 32'hA00,32'hA01,32'h300,32'h304, 0,0));
      vecs.push_back(mk(0,1,1, 32'h500,32'hC00,1, 2, 0,0, 2'b11,0, 32'hA02,32'hA03,32'h308,32'h30C, 0,0));
      vecs.push_back(mk(0,0,0, 0,0,0, 2, 0,0, 2'b11,0, 32'hB00,32'hB01,32'h400,32'h404, 0,0));
      vecs.push_back(mk(0,0,0, 0,0,0, 2, 0,0, 2'b11,0, 32'hB02,32'hB03,32'h408,32'h40C, 0,0));
      vecs.push_back(mk(0,0,0, 0,0,0, 1, 0,0, 2'b11,0, 32'hB03,32'hC00,32'h40C,32'h500, 0,0));
      vecs.push_back(mk(0,1,4, 32'h600,32'hD00,1, 2, 0,0, 2'b11,0, 32'hD00,32'hD01,32'h600,32'h604, 0,0));
      vecs.push_back(mk(0,0,0, 0,0,0, 2, 0,0, 2'b11,0, 32'hD02,32'hD03,32'h608,32'h60C, 0,0));
      vecs.push_back(mk(0,1,0, 32'h700,32'hE00,1, 0, 0,0, 2'b11,0, 32'hD02,32'hD03,32'h608,32'h60C, 0,0));
      vecs.push_back(mk(0,0,0, 0,0,0, 2, 0,0, 2'b00,0, 0,0,0,0, 0,0));

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i]);
         @(posedge clk);
         #1;
         checkVec(i, vecs[i]);
      end

      // Asynchronous reset in the middle of a high phase
      @(negedge clk);
      drive(mk(0,1,4, 32'h900,32'hF00,1, 0, 0,0, 2'b11,0, 0,0,0,0, 0,0));
      @(posedge clk);
      #1;
      check("arst.pre", 64'(IQ_valid_o), 64'd3);
      drive(idle);
      #1;
      rst = 1'b0;
      #1;
      check("arst.valid", 64'(IQ_valid_o), 64'd0);
      check("arst.inst",  IQ_inst_p_o,     64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("arst.after", 64'(IQ_valid_o), 64'd0);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end
endmodule
